instr_decode_stage: RTL and testbench
=====================================

# instr_decode_stage

Registered, parametrised instruction-decode stage. Accepts packed instruction words over a valid/ready handshake, splits them into data, opcode, control and register-address fields, and flags illegal opcodes. A two-entry skid buffer holds output, so the stage sustains one instruction per cycle under backpressure. It sits between the instruction fetch path and the register file / ALU issue logic, and replaces the earlier purely combinational field splitter.

## Interface
- DATA_W, 16, width of the immediate/data field
- OP_W, 4, opcode width
- REG_ADDR_W, 5, width of each register address field
- NUM_OPS, 12, number of legal opcodes; an opcode is legal when it is < NUM_OPS
- CNT_W, 16, width of the retired-instruction counter
- INSTR_W, derived: DATA_W+OP_W+2+3*REG_ADDR_W (37 at defaults); not overridable

- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; drops all buffered instructions
- in_valid  in  1  upstream word valid
- in_ready  out  1  stage can accept a word; registered
- in_instr  in  INSTR_W  packed word; fields from MSB to LSB: data, opcode, load_imm, rw, addr1, addr2, addr3
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  immediate/data field
- out_opcode  out  OP_W  opcode
- out_load_imm  out  1  load-immediate flag
- out_rw  out  1  register write enable; forced to 0 when out_illegal=1
- out_addr1, out_addr2, out_addr3  out  REG_ADDR_W each  register addresses
- out_illegal  out  1  opcode >= NUM_OPS
- instr_count  out  CNT_W  number of retired instructions (out_valid & out_ready); wraps

## Operation
- Storage: a main entry, which drives the out_* ports, and a skid entry. Each entry stores the decoded fields plus the illegal bit.
- States: EMPTY (no entry valid), ONE (main valid), TWO (main and skid valid). Define acc = in_valid & in_ready and ret = out_valid & out_ready.
  - EMPTY: acc -> ONE.
  - ONE: acc & !ret -> TWO (the word goes to skid). acc & ret -> ONE (the word goes to main). !acc & ret -> EMPTY.
  - TWO: ret -> ONE (skid moves to main). in_ready is 0 in TWO, so acc cannot occur.
- in_ready = (state != TWO), taken from registered state.
- Decode happens on entry to storage, so out_* are pure register outputs.
- Illegal opcode: the word is still passed through with out_illegal=1 and out_rw=0. All other fields are passed unchanged.
- flush: next state is EMPTY and in_ready is 1, regardless of handshakes in the same cycle. A word offered with flush is discarded. A retire in the flush cycle still increments instr_count.
- instr_count increments by 1 on every ret and wraps from 2^CNT_W-1 to 0.
- Reset values: state EMPTY, out_valid 0, in_ready 1, all out_* fields 0, out_illegal 0, instr_count 0. Reset asserted mid-transfer drops all entries immediately (asynchronous).

## Timing
- Latency: a word accepted at edge N is on out_* with out_valid=1 after edge N, with no combinational input-to-output path.
- Throughput: 1 word/cycle while out_ready=1.
- After out_ready falls, at most one further word is accepted, and only if that word is already in flight. in_ready falls the cycle after the skid entry fills.
- out_* remain stable while out_valid=1 and out_ready=0.
- Words are delivered in acceptance order, with no loss and no duplication.

## Test plan
- Reset: hold rst_n=0 while clk toggles -> out_valid=0, in_ready=1, instr_count=0, all fields 0.
- Single decode: send data=0xABCD, op=3, li=1, rw=1, a1=5, a2=10, a3=31, with out_ready=1 -> one cycle later out_data=0xABCD, out_opcode=3, out_load_imm=1, out_rw=1, addrs 5/10/31, out_illegal=0. instr_count=1 after the retire.
- Illegal opcode: send op=13 with rw=1 -> out_illegal=1, out_rw=0, other fields unchanged.
- Backpressure: stream words 1..6 with out_ready low for cycles 3–5 -> in_ready=0 while in TWO; outputs arrive as 1..6 in order, with no drop and no duplicate; out_* stable while stalled.
- Flush in TWO, with in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1; the offered word never appears at the output.
- Counter wrap: with CNT_W=4, retire 17 words -> instr_count=1.

Source files
------------

// File: rtl/instr_decode_stage.sv
// Purpose : registered instruction decode; splits packed words into fields and flags illegal opcodes.
// Latency : 1 cycle from accept edge to out_valid; every output comes straight from a flop.
// Backpressure: two-entry skid buffer (main + skid); in_ready drops only while both entries hold words.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   flush               synchronous drop of all buffered words (an offered word is discarded too)
//   in_valid/in_ready   upstream handshake, in_instr = {data, opcode, load_imm, rw, addr1, addr2, addr3}
//   out_valid/out_ready downstream handshake, out_* are the decoded fields of the oldest word
//   out_illegal         opcode >= NUM_OPS; such words pass through with out_rw forced low
//   instr_count         wrapping count of retired words (out_valid & out_ready)
module instr_decode_stage #(
  parameter int DATA_W     = 16,
  parameter int OP_W       = 4,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_OPS    = 12,
  parameter int CNT_W      = 16,
  localparam int INSTR_W   = DATA_W + OP_W + 2 + 3*REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    in_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [OP_W-1:0]       out_opcode,
  output logic                  out_load_imm,
  output logic                  out_rw,
  output logic [REG_ADDR_W-1:0] out_addr1,
  output logic [REG_ADDR_W-1:0] out_addr2,
  output logic [REG_ADDR_W-1:0] out_addr3,
  output logic                  out_illegal,
  output logic [CNT_W-1:0]      instr_count
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  // One extra bit so NUM_OPS == 2**OP_W (every opcode legal) still compares correctly.
  localparam logic [OP_W:0] NUM_OPS_C = (OP_W+1)'(NUM_OPS);

  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [OP_W-1:0]       opcode;
    logic                  load_imm;
    logic                  rw;
    logic [REG_ADDR_W-1:0] addr1;
    logic [REG_ADDR_W-1:0] addr2;
    logic [REG_ADDR_W-1:0] addr3;
  } instr_t;

  typedef struct packed {
    instr_t f;
    logic   illegal;
  } dec_t;

  logic [1:0] state_q;
  dec_t       main_q;
  dec_t       skid_q;
  dec_t       dec_in;
  instr_t     in_w;
  logic [CNT_W-1:0] cnt_q;
  logic       acc;
  logic       ret;

  assign in_w = instr_t'(in_instr);

  // Decode before storage so the out_* ports never see a combinational path.
  always_comb begin
    dec_in         = '0;
    dec_in.f       = in_w;
    dec_in.illegal = ({1'b0, in_w.opcode} >= NUM_OPS_C);
    if (dec_in.illegal) dec_in.f.rw = 1'b0;
  end

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign acc       = in_valid & in_ready;
  assign ret       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      // A retire in a flush cycle still happened downstream, so it is counted.
      if (ret) cnt_q <= cnt_q + CNT_W'(1);

      if (flush) begin
        state_q <= EMPTY;
      end else begin
        case (state_q)
          EMPTY: begin
            if (acc) begin
              main_q  <= dec_in;
              state_q <= ONE;
            end
          end
          ONE: begin
            if (acc && !ret) begin
              skid_q  <= dec_in;
              state_q <= TWO;
            end else if (acc && ret) begin
              main_q  <= dec_in;
            end else if (ret) begin
              state_q <= EMPTY;
            end
          end
          TWO: begin
            // in_ready is low here, so only the skid-to-main move can happen.
            if (ret) begin
              main_q  <= skid_q;
              state_q <= ONE;
            end
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

  assign out_data     = main_q.f.data;
  assign out_opcode   = main_q.f.opcode;
  assign out_load_imm = main_q.f.load_imm;
  assign out_rw       = main_q.f.rw;
  assign out_addr1    = main_q.f.addr1;
  assign out_addr2    = main_q.f.addr2;
  assign out_addr3    = main_q.f.addr3;
  assign out_illegal  = main_q.illegal;
  assign instr_count  = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: a queue of accepted words is the reference; the
// expected output is always the oldest queued word decoded by the opcode rules.
// A second instance with a 4-bit counter shares all inputs to cover counter wrap.
module tb_instr_decode_stage;

  localparam int IW = 37;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready;
  logic [IW-1:0] in_instr;

  logic        in_ready, out_valid, out_load_imm, out_rw, out_illegal;
  logic [15:0] out_data, instr_count;
  logic [3:0]  out_opcode;
  logic [4:0]  out_addr1, out_addr2, out_addr3;

  logic        in_ready4, out_valid4, out_load_imm4, out_rw4, out_illegal4;
  logic [15:0] out_data4;
  logic [3:0]  out_opcode4, instr_count4;
  logic [4:0]  out_addr1_4, out_addr2_4, out_addr3_4;

  instr_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_opcode(out_opcode), .out_load_imm(out_load_imm),
    .out_rw(out_rw), .out_addr1(out_addr1), .out_addr2(out_addr2),
    .out_addr3(out_addr3), .out_illegal(out_illegal), .instr_count(instr_count)
  );

  instr_decode_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_instr(in_instr),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_opcode(out_opcode4), .out_load_imm(out_load_imm4),
    .out_rw(out_rw4), .out_addr1(out_addr1_4), .out_addr2(out_addr2_4),
    .out_addr3(out_addr3_4), .out_illegal(out_illegal4), .instr_count(instr_count4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [IW-1:0] q[$];
  int model_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [15:0] d, input logic [3:0] op, input logic li,
                                       input logic rw, input logic [4:0] a1, input logic [4:0] a2,
                                       input logic [4:0] a3);
    return {d, op, li, rw, a1, a2, a3};
  endfunction

  // Expected {data, opcode, load_imm, rw, addr1, addr2, addr3, illegal} for a raw word.
  function automatic logic [37:0] expect_fields(input logic [IW-1:0] w);
    int   op;
    logic ill;
    op  = int'(w[20:17]);
    ill = (op >= 12);
    return {w[36:17], w[16], w[15] & ~ill, w[14:0], ill};
  endfunction

  function automatic logic [37:0] dut_fields();
    return {out_data, out_opcode, out_load_imm, out_rw, out_addr1, out_addr2, out_addr3, out_illegal};
  endfunction

  function automatic logic [37:0] dut4_fields();
    return {out_data4, out_opcode4, out_load_imm4, out_rw4, out_addr1_4, out_addr2_4, out_addr3_4,
            out_illegal4};
  endfunction

  task automatic check_outputs(input string tag);
    check_val({tag, "_in_ready"},  64'(in_ready),  64'(q.size() < 2));
    check_val({tag, "_out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    check_val({tag, "_count"},     64'(instr_count),  64'(model_cnt % 65536));
    check_val({tag, "_in_ready4"}, 64'(in_ready4),  64'(q.size() < 2));
    check_val({tag, "_out_valid4"},64'(out_valid4), 64'(q.size() > 0));
    check_val({tag, "_count4"},    64'(instr_count4), 64'(model_cnt % 16));
    if (q.size() > 0) begin
      check_val({tag, "_fields"},  64'(dut_fields()),  64'(expect_fields(q[0])));
      check_val({tag, "_fields4"}, 64'(dut4_fields()), 64'(expect_fields(q[0])));
    end
  endtask

  // Apply the currently driven inputs for one clock, advance the model, check at negedge.
  task automatic step(input string tag);
    bit acc, ret;
    acc = in_valid && (q.size() < 2);
    ret = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (ret) begin
      void'(q.pop_front());
      model_cnt++;
    end
    if (flush) q.delete();
    else if (acc) q.push_back(in_instr);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    q.delete();
    model_cnt = 0;
    check_outputs("reset");
    check_val("reset_fields",  64'(dut_fields()),  64'd0);
    check_val("reset_fields4", 64'(dut4_fields()), 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int  sent;
    bit  acc_now, saw_full;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    do_reset();

    // Single decode
    out_ready = 1'b1; in_valid = 1'b1;
    in_instr = mk(16'hABCD, 4'd3, 1'b1, 1'b1, 5'd5, 5'd10, 5'd31);
    step("single");
    in_valid = 1'b0;
    check_val("single_data",    64'(out_data),     64'hABCD);
    check_val("single_opcode",  64'(out_opcode),   64'd3);
    check_val("single_li",      64'(out_load_imm), 64'd1);
    check_val("single_rw",      64'(out_rw),       64'd1);
    check_val("single_addrs",   64'({out_addr1, out_addr2, out_addr3}), 64'({5'd5, 5'd10, 5'd31}));
    check_val("single_illegal", 64'(out_illegal),  64'd0);
    step("single_ret");
    check_val("single_cnt", 64'(instr_count), 64'd1);

    // Illegal opcode
    in_valid = 1'b1;
    in_instr = mk(16'h1234, 4'd13, 1'b0, 1'b1, 5'd7, 5'd8, 5'd9);
    step("illegal");
    in_valid = 1'b0;
    check_val("illegal_flag",   64'(out_illegal), 64'd1);
    check_val("illegal_rw",     64'(out_rw),      64'd0);
    check_val("illegal_opcode", 64'(out_opcode),  64'd13);
    check_val("illegal_data",   64'(out_data),    64'h1234);
    step("illegal_ret");

    // Backpressure: words 1..6, out_ready low in cycles 3..5
    sent = 0; saw_full = 1'b0;
    for (int cyc = 1; cyc <= 40 && !(sent == 6 && q.size() == 0); cyc++) begin
      in_valid  = (sent < 6);
      in_instr  = mk(16'(sent + 1), 4'd1, 1'b0, 1'b1, 5'(sent + 1), 5'd0, 5'd0);
      out_ready = !(cyc >= 3 && cyc <= 5);
      acc_now   = in_valid && (q.size() < 2);
      step("bp");
      if (acc_now) sent++;
      if (!in_ready) saw_full = 1'b1;
    end
    in_valid = 1'b0;
    check_val("bp_sent",     64'(sent),     64'd6);
    check_val("bp_drained",  64'(q.size()), 64'd0);
    check_val("bp_saw_full", 64'(saw_full), 64'd1);

    // Flush while both entries are full, with a word offered in the same cycle
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = mk(16'h0A0A, 4'd2, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3); step("fill_a");
    in_instr = mk(16'h0B0B, 4'd2, 1'b0, 1'b1, 5'd4, 5'd5, 5'd6); step("fill_b");
    check_val("fill_two", 64'(in_ready), 64'd0);
    flush = 1'b1;
    in_instr = mk(16'hDEAD, 4'd5, 1'b1, 1'b1, 5'd9, 5'd9, 5'd9);
    step("flush");
    flush = 1'b0; in_valid = 1'b0;
    check_val("flush_out_valid", 64'(out_valid), 64'd0);
    check_val("flush_in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    repeat (3) step("post_flush");

    // Counter wrap on the 4-bit instance: 17 retires
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_instr = IW'({$urandom(), $urandom()});
      step("wrap");
    end
    in_valid = 1'b0;
    step("wrap_last");
    check_val("wrap4",  64'(instr_count4), 64'd1);
    check_val("wrap16", 64'(instr_count),  64'd17);

    // Random traffic with occasional flush
    do_reset();
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_instr  = IW'({$urandom(), $urandom()});
      step("rand");
    end
    flush = 1'b0;

    // Asynchronous reset with words buffered
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = mk(16'h5555, 4'd1, 1'b0, 1'b0, 5'd1, 5'd1, 5'd1); step("pre_rst");
    in_instr = mk(16'h6666, 4'd1, 1'b0, 1'b0, 5'd2, 5'd2, 5'd2); step("pre_rst");
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_out_valid", 64'(out_valid),   64'd0);
    check_val("arst_in_ready",  64'(in_ready),    64'd1);
    check_val("arst_count",     64'(instr_count), 64'd0);
    check_val("arst_fields",    64'(dut_fields()), 64'd0);
    q.delete();
    model_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
